// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF1 next-PC generator: reset PC, redirect
// source encoding, fetch FSM states and the slot-mask helper.
package pc_gen_pkg;

    localparam logic [31:0] PC_INITIAL = 32'h1c00_0000;

    // Redirect-source priority encoding, larger value wins.
    localparam logic [1:0] SRC_EXCP = 2'd2;
    localparam logic [1:0] SRC_BRU  = 2'd1;
    localparam logic [1:0] SRC_PD   = 2'd0;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        HALT_ADEF = 2'd2
    } fetch_state_e;

    // Thermometer mask over up to 8 slots: bit i set iff i >= start.
    function automatic logic [7:0] slot_mask(input logic [2:0] start);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (3'(i) >= start);
        end
        return m;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a predecode redirect that arrived while the fetch handshake was
// blocked, until the next fire consumes it or a backend redirect kills it.
module pc_redirect_buf
    import pc_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_i,
    input  logic [31:0] set_target_i,
    input  logic        clr_i,
    input  logic        kill_i,
    output logic        pend_valid_o,
    output logic [31:0] pend_target_o
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Kill beats set beats clear; a newer set overwrites an older target.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (kill_i) begin
            pend_valid_d = 1'b0;
        end else if (set_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = set_target_i;
        end else if (clr_i) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pend_valid_o  = pend_valid_q;
    assign pend_target_o = pend_target_q;

endmodule

// File: rtl/pc_gen.sv
// IF1 next-PC generator: fetch FSM, redirect arbitration and the aligned
// fetch-group request toward the icache.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = pc_gen_pkg::PC_INITIAL,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [31:0]            fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   fetch_adef,
    output logic                   fetch_flush,
    input  logic                   excp_redirect,
    input  logic [31:0]            excp_target,
    input  logic                   bru_redirect,
    input  logic [31:0]            bru_target,
    input  logic                   pd_redirect,
    input  logic [31:0]            pd_target,
    output logic [1:0]             dbg_state,
    output logic                   dbg_pend_valid
);

    localparam int GROUP_BYTES = FETCH_WIDTH * 4;
    localparam int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    // Handshake: a request transfers on a cycle with fetch_valid & fetch_ready
    // & ~stall; until then fetch_pc/mask/adef stay stable unless excp/bru hits.
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         fetch_flush_q, fetch_flush_d;

    logic         fire;
    logic         hard_redirect;
    logic [1:0]   redir_src;
    logic [31:0]  hard_target;
    logic [31:0]  seq_pc;
    logic [2:0]   slot_idx;
    logic         pend_set, pend_clr, pend_valid;
    logic [31:0]  pend_target;

    assign fetch_valid   = (state_q == RUN);
    assign fetch_pc      = fetch_pc_q;
    assign fetch_flush   = fetch_flush_q;
    assign fetch_adef    = (fetch_pc_q[1:0] != 2'b00);
    assign fire          = fetch_valid & fetch_ready & ~stall;
    assign hard_redirect = excp_redirect | bru_redirect;
    assign seq_pc        = (fetch_pc_q & ~32'(GROUP_BYTES - 1)) + 32'(GROUP_BYTES);
    assign slot_idx      = 3'(fetch_pc_q[SLOT_W+1:2]);

    always_comb begin
        redir_src = SRC_PD;
        if (excp_redirect) begin
            redir_src = SRC_EXCP;
        end else if (bru_redirect) begin
            redir_src = SRC_BRU;
        end
        hard_target = (redir_src == SRC_EXCP) ? excp_target : bru_target;
    end

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_one
            assign fetch_mask = 1'b1;
        end else begin : g_mask_multi
            // A misaligned PC presents only its own slot.
            assign fetch_mask = fetch_adef ? FETCH_WIDTH'(8'd1 << slot_idx)
                                           : FETCH_WIDTH'(slot_mask(slot_idx));
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_flush_d = 1'b0;
        pend_set      = 1'b0;
        pend_clr      = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
        if (hard_redirect) begin
            fetch_pc_d    = hard_target;
            state_d       = RUN;
            fetch_flush_d = 1'b1;
        end else if (fire) begin
            pend_clr = 1'b1;
            if (fetch_adef) begin
                state_d = HALT_ADEF;
            end else if (pd_redirect) begin
                fetch_pc_d = pd_target;
            end else if (pend_valid) begin
                fetch_pc_d = pend_target;
            end else begin
                fetch_pc_d = seq_pc;
            end
        end else if (pd_redirect && state_q != HALT_ADEF) begin
            pend_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= PC_INIT;
            fetch_flush_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_flush_q <= fetch_flush_d;
        end
    end

    pc_redirect_buf u_pend (
        .clk          (clk),
        .rst          (rst),
        .set_i        (pend_set),
        .set_target_i (pd_target),
        .clr_i        (pend_clr),
        .kill_i       (hard_redirect),
        .pend_valid_o (pend_valid),
        .pend_target_o(pend_target)
    );

    assign dbg_state      = state_q;
    assign dbg_pend_valid = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with FETCH_WIDTH=2: boot, sequential fetch,
// redirects, pending predecode target, ADEF halt and async reset.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_mask;
    logic        fetch_adef;
    logic        fetch_flush;
    logic        excp_redirect;
    logic [31:0] excp_target;
    logic        bru_redirect;
    logic [31:0] bru_target;
    logic        pd_redirect;
    logic [31:0] pd_target;
    logic [1:0]  dbg_state;
    logic        dbg_pend_valid;

    int vectors;
    int miscompares;

    pc_gen #(.FETCH_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_mask    (fetch_mask),
        .fetch_adef    (fetch_adef),
        .fetch_flush   (fetch_flush),
        .excp_redirect (excp_redirect),
        .excp_target   (excp_target),
        .bru_redirect  (bru_redirect),
        .bru_target    (bru_target),
        .pd_redirect   (pd_redirect),
        .pd_target     (pd_target),
        .dbg_state     (dbg_state),
        .dbg_pend_valid(dbg_pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
        excp_redirect = 1'b0; excp_target = '0;
        bru_redirect = 1'b0; bru_target = '0;
        pd_redirect = 1'b0; pd_target = '0;
        repeat (2) @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c000000) begin miscompares++; $display("FAIL rst_pc: got %h exp 1c000000", fetch_pc); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b exp 0", fetch_valid); end
        vectors++; if (fetch_flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush: got %b exp 0", fetch_flush); end
        vectors++; if (fetch_mask !== 2'b11) begin miscompares++; $display("FAIL rst_mask: got %b exp 11", fetch_mask); end
        vectors++; if (fetch_adef !== 1'b0) begin miscompares++; $display("FAIL rst_adef: got %b exp 0", fetch_adef); end
        vectors++; if (dbg_pend_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pend: got %b exp 0", dbg_pend_valid); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc[3];
        exp_pc[0] = 32'h1c000000; exp_pc[1] = 32'h1c000008; exp_pc[2] = 32'h1c000010;
        // Still in the negedge where reset was released: BOOT cycle follows.
        vectors++; if (fetch_valid !== 1'b0 || dbg_state !== BOOT) begin miscompares++; $display("FAIL boot: valid %b state %0d exp valid 0 state BOOT", fetch_valid, dbg_state); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc[i] || fetch_mask !== 2'b11) begin
                miscompares++; $display("FAIL seq_%0d: valid %b pc %h mask %b exp 1 %h 11", i, fetch_valid, fetch_pc, fetch_mask, exp_pc[i]);
            end
        end
    endtask

    task automatic test_bru_redirect();
        fetch_ready = 1'b0; bru_redirect = 1'b1; bru_target = 32'h1c000104;
        @(negedge clk);
        bru_redirect = 1'b0;
        vectors++; if (fetch_pc !== 32'h1c000104 || fetch_mask !== 2'b10) begin miscompares++; $display("FAIL bru_pc: pc %h mask %b exp 1c000104 10", fetch_pc, fetch_mask); end
        vectors++; if (fetch_flush !== 1'b1) begin miscompares++; $display("FAIL bru_flush: got %b exp 1", fetch_flush); end
        @(negedge clk);
        vectors++; if (fetch_flush !== 1'b0 || fetch_pc !== 32'h1c000104 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL bru_hold: flush %b pc %h valid %b exp 0 1c000104 1", fetch_flush, fetch_pc, fetch_valid); end
        fetch_ready = 1'b1;
        @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c000108 || fetch_mask !== 2'b11) begin miscompares++; $display("FAIL bru_next: pc %h mask %b exp 1c000108 11", fetch_pc, fetch_mask); end
    endtask

    task automatic test_pending_pd();
        stall = 1'b1; pd_redirect = 1'b1; pd_target = 32'h1c000200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (fetch_pc !== 32'h1c000108 || dbg_pend_valid !== 1'b1) begin
                miscompares++; $display("FAIL pend_hold_%0d: pc %h pend %b exp 1c000108 1", i, fetch_pc, dbg_pend_valid);
            end
        end
        stall = 1'b0; pd_redirect = 1'b0; pd_target = 32'h0;
        @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c000200 || fetch_flush !== 1'b0 || dbg_pend_valid !== 1'b0) begin
            miscompares++; $display("FAIL pend_use: pc %h flush %b pend %b exp 1c000200 0 0", fetch_pc, fetch_flush, dbg_pend_valid);
        end
    endtask

    task automatic test_excp_over_bru();
        stall = 1'b1; pd_redirect = 1'b1; pd_target = 32'h1c000400;
        @(negedge clk);
        vectors++; if (dbg_pend_valid !== 1'b1 || fetch_pc !== 32'h1c000200) begin miscompares++; $display("FAIL prio_pend: pend %b pc %h exp 1 1c000200", dbg_pend_valid, fetch_pc); end
        pd_redirect = 1'b0;
        excp_redirect = 1'b1; excp_target = 32'h1c008000;
        bru_redirect = 1'b1; bru_target = 32'h1c000300;
        @(negedge clk);
        excp_redirect = 1'b0; bru_redirect = 1'b0;
        vectors++; if (fetch_pc !== 32'h1c008000) begin miscompares++; $display("FAIL prio_pc: got %h exp 1c008000", fetch_pc); end
        vectors++; if (dbg_pend_valid !== 1'b0 || fetch_flush !== 1'b1) begin miscompares++; $display("FAIL prio_kill: pend %b flush %b exp 0 1", dbg_pend_valid, fetch_flush); end
        stall = 1'b0;
        @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c008008) begin miscompares++; $display("FAIL prio_after: got %h exp 1c008008", fetch_pc); end
    endtask

    task automatic test_adef();
        fetch_ready = 1'b0; bru_redirect = 1'b1; bru_target = 32'h1c000102;
        @(negedge clk);
        bru_redirect = 1'b0;
        vectors++; if (fetch_adef !== 1'b1 || fetch_mask !== 2'b01 || fetch_valid !== 1'b1) begin
            miscompares++; $display("FAIL adef_req: adef %b mask %b valid %b exp 1 01 1", fetch_adef, fetch_mask, fetch_valid);
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        vectors++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h1c000102 || dbg_state !== HALT_ADEF) begin
            miscompares++; $display("FAIL adef_halt: valid %b pc %h state %0d exp 0 1c000102 HALT", fetch_valid, fetch_pc, dbg_state);
        end
        pd_redirect = 1'b1; pd_target = 32'h1c000500;
        @(negedge clk);
        pd_redirect = 1'b0;
        vectors++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h1c000102 || dbg_pend_valid !== 1'b0) begin
            miscompares++; $display("FAIL adef_pd_ignored: valid %b pc %h pend %b exp 0 1c000102 0", fetch_valid, fetch_pc, dbg_pend_valid);
        end
        excp_redirect = 1'b1; excp_target = 32'h1c008000;
        @(negedge clk);
        excp_redirect = 1'b0;
        vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h1c008000 || fetch_adef !== 1'b0 || fetch_flush !== 1'b1) begin
            miscompares++; $display("FAIL adef_resume: valid %b pc %h adef %b flush %b exp 1 1c008000 0 1", fetch_valid, fetch_pc, fetch_adef, fetch_flush);
        end
        @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c008008) begin miscompares++; $display("FAIL adef_seq: got %h exp 1c008008", fetch_pc); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; pd_redirect = 1'b1; pd_target = 32'h1c000600;
        @(negedge clk);
        pd_redirect = 1'b0;
        vectors++; if (dbg_pend_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pend_set: got %b exp 1", dbg_pend_valid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (fetch_pc !== 32'h1c000000 || fetch_valid !== 1'b0 || fetch_flush !== 1'b0 || fetch_mask !== 2'b11) begin
            miscompares++; $display("FAIL arst_out: pc %h valid %b flush %b mask %b exp 1c000000 0 0 11", fetch_pc, fetch_valid, fetch_flush, fetch_mask);
        end
        vectors++; if (dbg_pend_valid !== 1'b0 || dbg_state !== BOOT) begin miscompares++; $display("FAIL arst_state: pend %b state %0d exp 0 BOOT", dbg_pend_valid, dbg_state); end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL arst_boot: valid %b exp 0", fetch_valid); end
        @(negedge clk);
        vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h1c000000) begin miscompares++; $display("FAIL arst_run: valid %b pc %h exp 1 1c000000", fetch_valid, fetch_pc); end
        @(negedge clk);
        vectors++; if (fetch_pc !== 32'h1c000008) begin miscompares++; $display("FAIL arst_no_stale: got %h exp 1c000008", fetch_pc); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_bru_redirect();
        test_pending_pd();
        test_excp_over_bru();
        test_adef();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation PC generator for the IF1 stage. It fetches FETCH_WIDTH instructions per cycle as an aligned group.
- It arbitrates three redirect sources: exception/ertn, backend mispredict and predecode branch.
- It handshakes with the icache (valid/ready) and buffers a predecode redirect that arrives while fetch is blocked.
- On a misaligned PC it halts fetch after raising ADEF, and resumes only on a backend or exception redirect.

Parameters:
- PC_INITIAL, 32'h1c00_0000, fetch_pc value at reset.
- FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..8.
- GROUP_BYTES, FETCH_WIDTH*4, derived; bytes per fetch group.
- SLOT_W, log2(FETCH_WIDTH) (min 1), derived; slot index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  global pipeline stall; blocks the fetch handshake.
- fetch_ready  in  1  icache accepts a request this cycle.
- fetch_valid  out  1  request valid.
- fetch_pc  out  32  PC of the first valid slot; registered.
- fetch_mask  out  FETCH_WIDTH  per-slot valid bits.
- fetch_adef  out  1  fetch_pc[1:0]!=0.
- fetch_flush  out  1  one-cycle pulse: in-flight IF requests are dead.
- excp_redirect  in  1  exception/ertn redirect; highest priority.
- excp_target  in  32  target for excp_redirect.
- bru_redirect  in  1  backend mispredict redirect.
- bru_target  in  32  target for bru_redirect.
- pd_redirect  in  1  predecode taken-branch redirect; lowest priority.
- pd_target  in  32  target for pd_redirect.

Behaviour:
- fire = fetch_valid & fetch_ready & ~stall.
- Sequential successor: seq_pc = (fetch_pc & ~(GROUP_BYTES-1)) + GROUP_BYTES. Wraps modulo 2^32, no flag.
- States:
  - BOOT: after reset, lasts one cycle; fetch_valid=0; then goes to RUN.
  - RUN: fetch_valid=1.
  - HALT_ADEF: fetch_valid=0.
- Reset values (asynchronous):
  - fetch_pc=PC_INITIAL, state=BOOT, fetch_valid=0, fetch_flush=0.
  - pend_valid=0, pend_target=0.
  - fetch_adef=0 and fetch_mask=all-ones follow from the aligned PC_INITIAL.
- Priority each cycle:
  - excp_redirect or bru_redirect (excp over bru) applies regardless of stall, fetch_ready or state:
    - fetch_pc <= target; state <= RUN.
    - fetch_flush=1 next cycle; pend_valid <= 0.
    - Any unfired current request is dropped; the icache treats fetch_flush as retraction.
  - Otherwise, if fire:
    - pd_redirect this cycle: fetch_pc <= pd_target.
    - else pend_valid: fetch_pc <= pend_target, then clear pend_valid.
    - else: fetch_pc <= seq_pc.
  - Otherwise (no fire): pd_redirect latches pend_target <= pd_target and pend_valid <= 1. A newer pd overwrites an older pending one. fetch_pc holds.
- A predecode redirect never raises fetch_flush; the predecode stage squashes its own group.
- fetch_mask:
  - bit i = 1 iff i >= fetch_pc[SLOT_W+1:2].
  - For FETCH_WIDTH=1 it is constant 1.
- ADEF:
  - When fetch_adef=1, fetch_mask is one-hot at fetch_pc[SLOT_W+1:2]; the request is still presented.
  - On its fire, state <= HALT_ADEF and fetch_pc holds.
  - HALT_ADEF ignores pd_redirect and does not set pending. It exits only via excp/bru redirect.
- fetch_valid, fetch_pc, fetch_mask and fetch_adef stay stable while fetch_valid & ~fire, unless an excp/bru redirect occurs.
- Reset asserted mid-operation: immediate return to the reset values; any pending target is lost.

Decomposition:
- Shared package:
  - PC_INITIAL.
  - Redirect-source priority encoding: EXCP=2, BRU=1, PD=0.
  - The fetch-state enum: BOOT, RUN, HALT_ADEF.
  - The slot-mask function: start index to thermometer mask.
- One natural sub-module, pc_redirect_buf: the pending pd redirect register with its set/clear/kill logic.
- Next-PC selection and the FSM stay in pc_gen.

Test Plan (FETCH_WIDTH=2):
- Reset release, fetch_ready=1, stall=0:
  - BOOT cycle: fetch_valid=0.
  - Then fetch_pc = 1c000000, 1c000008, 1c000010 on consecutive cycles, fetch_mask=2'b11.
- bru_redirect with bru_target=1c000104 while fetch_ready=0:
  - Next cycle: fetch_pc=1c000104, mask=2'b10, fetch_flush=1.
  - After fire: 1c000108, mask=2'b11.
- pd_redirect with target 1c000200 at cycle t while stall=1, held until t+2:
  - fetch_pc unchanged and pend_valid=1 through t+2.
  - Fire at t+3, then fetch_pc=1c000200 with no flush.
- excp_redirect (1c008000) and bru_redirect (1c000300) in the same cycle with a pending pd:
  - fetch_pc=1c008000, pend cleared, fetch_flush=1.
- bru_target=1c000102:
  - fetch_adef=1, mask=2'b01.
  - After fire: fetch_valid=0 and pd_redirect ignored.
  - excp_redirect to 1c008000 resumes with fetch_valid=1.
- rst pulsed asynchronously mid-cycle while pend_valid=1:
  - Outputs return to the reset values immediately.
  - After release: BOOT, then fetch_pc=1c000000; the old pending target is never used.
